// File: rtl/mole_anim_pkg.sv
// Shared op codes, sprite-select codes and FSM state encoding for the mole animator.
package mole_anim_pkg;

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_POP   = 2'd1;
  localparam logic [1:0] CMD_WHACK = 2'd2;
  localparam logic [1:0] CMD_MISS  = 2'd3;

  localparam logic [1:0] SPR_NONE   = 2'd0;
  localparam logic [1:0] SPR_NORMAL = 2'd1;
  localparam logic [1:0] SPR_DEAD   = 2'd2;
  localparam logic [1:0] SPR_HAPPY  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASCEND  = 2'd1,
    ST_UP      = 2'd2,
    ST_DESCEND = 2'd3
  } state_t;

endpackage

// File: rtl/mole_step_ticker.sv
// Animation step divider: counts 0..STEP_DIV-1 while enabled, tick on the last count.
module mole_step_ticker #(
  parameter int STEP_DIV = 33750
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] count;

  // Divider counter; clear has priority so the first tick is a full period after a state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end else begin
      count <= count;
    end
  end

  assign tick = en & (count == LAST);

endmodule

// File: rtl/mole_sprite_animator.sv
// N-hole mole pop-up animator: FSM, rise arithmetic and hole table.
// Optional auto-miss timeout in UP is enabled by defining MOLE_ANIM_TIMEOUT_EN.
module mole_sprite_animator
  import mole_anim_pkg::*;
#(
  parameter int N_HOLES       = 8,
  parameter int SPRITE_H      = 256,
  parameter int STEP_DIV      = 33750,
  parameter int STEP_PX       = 1,
  parameter logic [11*N_HOLES-1:0] HOLE_X =
    {11'd747, 11'd406, 11'd65, 11'd747, 11'd65, 11'd747, 11'd406, 11'd65},
  parameter logic [10*N_HOLES-1:0] HOLE_Y =
    {10'd512, 10'd512, 10'd512, 10'd256, 10'd256, 10'd0, 10'd0, 10'd0},
  parameter int TIMEOUT_TICKS = 600
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_hole,
  output logic [10:0] spr_x,
  output logic [9:0]  cell_y,
  output logic [9:0]  spr_y,
  output logic        spr_vis,
  output logic [1:0]  spr_sel,
  output logic        busy,
  output logic        up_done,
  output logic        down_done,
  output logic        cmd_err,
  output logic        timeout
);

  localparam int RW = $clog2(SPRITE_H + 1);
  localparam logic [RW:0]   H_EXT  = (RW+1)'(SPRITE_H);
  localparam logic [RW:0]   PX_EXT = (RW+1)'(STEP_PX);
  localparam logic [RW-1:0] H_TOP  = RW'(SPRITE_H);

  state_t        state, state_nx;
  logic [RW-1:0] rise, rise_nx, rise_up_s, rise_dn_s;
  logic [RW:0]   rise_sum_s;
  logic [10:0]   hole_x_s, x_nx;
  logic [9:0]    hole_y_s, y_nx;
  logic [1:0]    sel_nx;
  logic          act_s, hole_ok_s, tick_s, clr_s;
  logic          up_p, dn_p, err_p, to_p;

  // Commands other than NOP are the only ones that can change anything.
  assign act_s     = cmd_valid & cmd_ready & (cmd_op != CMD_NOP);
  assign hole_ok_s = ({1'b0, cmd_hole} < 5'(N_HOLES));

  // Saturating rise steps; the extra bit keeps rise+STEP_PX from wrapping.
  assign rise_sum_s = {1'b0, rise} + PX_EXT;
  assign rise_up_s  = (rise_sum_s >= H_EXT) ? H_TOP : rise_sum_s[RW-1:0];
  assign rise_dn_s  = ({1'b0, rise} <= PX_EXT) ? '0 : rise - PX_EXT[RW-1:0];

  // Hole table lookup by requested index.
  always_comb begin
    hole_x_s = HOLE_X[10:0];
    hole_y_s = HOLE_Y[9:0];
    for (int i = 0; i < N_HOLES; i++) begin
      hole_x_s = (cmd_hole == 4'(i)) ? HOLE_X[11*i +: 11] : hole_x_s;
      hole_y_s = (cmd_hole == 4'(i)) ? HOLE_Y[10*i +: 10] : hole_y_s;
    end
  end

  assign clr_s = (state_nx != state) | (state == ST_IDLE);

  mole_step_ticker #(.STEP_DIV(STEP_DIV)) u_ticker (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_s),
    .en      (state != ST_IDLE),
    .tick    (tick_s)
  );

`ifdef MOLE_ANIM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);
  logic [TW-1:0] to_cnt;

  // Ticks spent fully up; restarts whenever UP is entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (state_nx != ST_UP) begin
      to_cnt <= '0;
    end else if ((state == ST_UP) && tick_s && !act_s) begin
      to_cnt <= to_cnt + TW'(1);
    end else begin
      to_cnt <= to_cnt;
    end
  end
`endif

  // Next-state logic; an accepted command pre-empts a tick on the same cycle.
  always_comb begin
    state_nx = state;
    rise_nx  = rise;
    sel_nx   = spr_sel;
    x_nx     = spr_x;
    y_nx     = cell_y;
    up_p     = 1'b0;
    dn_p     = 1'b0;
    err_p    = 1'b0;
    to_p     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (act_s && (cmd_op == CMD_POP) && hole_ok_s) begin
          x_nx     = hole_x_s;
          y_nx     = hole_y_s;
          rise_nx  = '0;
          sel_nx   = SPR_NORMAL;
          state_nx = ST_ASCEND;
        end else begin
          err_p = act_s;
        end
      end
      ST_ASCEND, ST_UP: begin
        if (act_s) begin
          if (cmd_op == CMD_POP) begin
            err_p = 1'b1;
          end else begin
            sel_nx   = (cmd_op == CMD_WHACK) ? SPR_DEAD : SPR_HAPPY;
            state_nx = ST_DESCEND;
          end
        end else if (tick_s && (state == ST_ASCEND)) begin
          rise_nx = rise_up_s;
          if (rise_up_s == H_TOP) begin
            state_nx = ST_UP;
            up_p     = 1'b1;
          end else begin
            state_nx = ST_ASCEND;
          end
`ifdef MOLE_ANIM_TIMEOUT_EN
        end else if (tick_s && (to_cnt == TO_LAST)) begin
          sel_nx   = SPR_HAPPY;
          state_nx = ST_DESCEND;
          to_p     = 1'b1;
`endif
        end else begin
          state_nx = state;
        end
      end
      ST_DESCEND: begin
        if (tick_s) begin
          rise_nx = rise_dn_s;
          if (rise_dn_s == '0) begin
            sel_nx   = SPR_NONE;
            state_nx = ST_IDLE;
            dn_p     = 1'b1;
          end else begin
            state_nx = ST_DESCEND;
          end
        end else begin
          state_nx = ST_DESCEND;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rise      <= '0;
      spr_x     <= HOLE_X[10:0];
      cell_y    <= HOLE_Y[9:0];
      spr_y     <= HOLE_Y[9:0] + 10'(SPRITE_H);
      spr_vis   <= 1'b0;
      spr_sel   <= SPR_NONE;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      up_done   <= 1'b0;
      down_done <= 1'b0;
      cmd_err   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      rise      <= rise_nx;
      spr_x     <= x_nx;
      cell_y    <= y_nx;
      spr_y     <= y_nx + 10'(SPRITE_H) - 10'(rise_nx);
      spr_vis   <= (rise_nx != '0);
      spr_sel   <= sel_nx;
      busy      <= (state_nx != ST_IDLE);
      cmd_ready <= (state_nx != ST_DESCEND);
      up_done   <= up_p;
      down_done <= dn_p;
      cmd_err   <= err_p;
      timeout   <= to_p;
    end
  end

endmodule

// File: tb/tb_mole_sprite_animator.sv
// Randomised scoreboard bench for mole_sprite_animator against a time-arithmetic reference model.
module tb_mole_sprite_animator;

  localparam int DIV = 4;
  localparam int H   = 16;
  localparam int PX  = 3;
  localparam int TT  = 5;
`ifdef MOLE_ANIM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [3:0]  cmd_hole = 4'd0;
  logic        cmd_ready, spr_vis, busy, up_done, down_done, cmd_err, timeout;
  logic [10:0] spr_x;
  logic [9:0]  cell_y, spr_y;
  logic [1:0]  spr_sel;

  mole_sprite_animator #(
    .N_HOLES(8), .SPRITE_H(H), .STEP_DIV(DIV), .STEP_PX(PX), .TIMEOUT_TICKS(TT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_hole(cmd_hole), .spr_x(spr_x), .cell_y(cell_y),
    .spr_y(spr_y), .spr_vis(spr_vis), .spr_sel(spr_sel), .busy(busy),
    .up_done(up_done), .down_done(down_done), .cmd_err(cmd_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic up, dn, err, to;
    logic [10:0] x;
    logic [9:0]  cy, sy;
    logic        vis;
    logic [1:0]  sel;
    logic        busy, rdy;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } ev_t;

  ev_t  q[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   hx[8] = '{65, 406, 747, 65, 747, 65, 406, 747};
  int   hy[8] = '{0, 0, 0, 256, 256, 512, 512, 512};

  // Reference model: phase 0 idle, 1 rising, 2 up, 3 falling; ticks fall on multiples of DIV after entry.
  int   m_ph, m_rise, m_hole, m_sel, m_entry, m_ups;
  obs_t m_prev, d_prev;

  function automatic obs_t strip(obs_t o);
    o.up = 1'b0; o.dn = 1'b0; o.err = 1'b0; o.to = 1'b0;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o = '0;
    o.x = 11'd65; o.cy = 10'd0; o.sy = 10'(H); o.rdy = 1'b1;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.up = up_done; o.dn = down_done; o.err = cmd_err; o.to = timeout;
    o.x = spr_x; o.cy = cell_y; o.sy = spr_y; o.vis = spr_vis; o.sel = spr_sel;
    o.busy = busy; o.rdy = cmd_ready;
    return o;
  endfunction

  function automatic bit tick_at(int t);
    return (m_ph != 0) && (t > m_entry) && ((t - m_entry) % DIV == 0);
  endfunction

  task automatic model_reset();
    m_ph = 0; m_rise = 0; m_hole = 0; m_sel = 0; m_entry = 0; m_ups = 0;
    m_prev = reset_obs();
    q.delete();
  endtask

  task automatic model_advance(bit v, int op, int hole);
    int   t = cyc + 1;
    bit   up = 0, dn = 0, err = 0, to = 0;
    bit   act = v && (m_ph != 3) && (op != 0);
    bit   tk = tick_at(t);
    obs_t o;
    if (m_ph == 0) begin
      if (act && op == 1 && hole < 8) begin
        m_hole = hole; m_rise = 0; m_sel = 1; m_ph = 1; m_entry = t;
      end else if (act) err = 1;
    end else if (m_ph == 1 || m_ph == 2) begin
      if (act && op == 1) err = 1;
      else if (act) begin
        m_sel = (op == 2) ? 2 : 3; m_ph = 3; m_entry = t;
      end else if (tk && m_ph == 1) begin
        m_rise = (m_rise + PX > H) ? H : m_rise + PX;
        if (m_rise == H) begin m_ph = 2; m_entry = t; m_ups = 0; up = 1; end
      end else if (tk) begin
        m_ups++;
        if (TO_EN && m_ups == TT) begin m_sel = 3; m_ph = 3; m_entry = t; to = 1; end
      end
    end else if (tk) begin
      m_rise = (m_rise < PX) ? 0 : m_rise - PX;
      if (m_rise == 0) begin m_ph = 0; m_sel = 0; dn = 1; end
    end
    o.up = up; o.dn = dn; o.err = err; o.to = to;
    o.x = 11'(hx[m_hole]); o.cy = 10'(hy[m_hole]); o.sy = 10'(hy[m_hole] + H - m_rise);
    o.vis = (m_rise != 0); o.sel = 2'(m_sel); o.busy = (m_ph != 0); o.rdy = (m_ph != 3);
    if (up || dn || err || to || strip(o) != m_prev) q.push_back('{t, o});
    m_prev = strip(o);
  endtask

  // Called at a falling edge: drive inputs for the next rising edge, predict, advance one cycle.
  task automatic step(bit v, int op, int hole);
    cmd_valid = v; cmd_op = 2'(op); cmd_hole = 4'(hole);
    model_advance(v, op, hole);
    @(negedge clk);
  endtask

  task automatic wait_phase(int ph, int budget);
    for (int i = 0; i < budget && m_ph != ph; i++) step(0, 0, 0);
    checks++;
    if (m_ph != ph) begin
      errors++;
      $display("FAIL wait_phase got phase %0d required %0d", m_ph, ph);
    end
  endtask

  // Monitor: whenever the DUT pulses or changes a visible output, pop and compare the prediction.
  always @(posedge clk) begin
    obs_t o;
    ev_t  e;
    #1;
    cyc++;
    if (!reset_n) begin
      d_prev = reset_obs();
    end else begin
      o = dut_obs();
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL missed_event cyc=%0d got none required %h at cyc %0d", cyc, e.o, e.cyc);
      end
      if (o.up || o.dn || o.err || o.to || strip(o) != d_prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d got %h required nothing", cyc, o);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.o != o) begin
            errors++;
            $display("FAIL output cyc=%0d got %h required %h at cyc %0d", cyc, o, e.o, e.cyc);
          end
        end
      end
      d_prev = strip(o);
    end
  end

  initial begin
    obs_t o;
    model_reset();
    repeat (3) @(negedge clk);
    o = dut_obs();
    checks++;
    if (o != reset_obs()) begin
      errors++;
      $display("FAIL reset_state got %h required %h", o, reset_obs());
    end
    reset_n = 1'b1;
    @(negedge clk);

    // Full pop of hole 2, then whack from the top.
    step(1, 1, 2);
    wait_phase(2, 60);
    step(0, 0, 0); step(0, 0, 0);
    step(1, 2, 0);
    wait_phase(0, 60);

    // Illegal commands in IDLE, ignored commands while descending.
    step(1, 1, 9);
    step(1, 2, 0);
    step(1, 3, 0);
    step(1, 0, 0);
    step(1, 1, 3);
    wait_phase(2, 60);
    step(1, 1, 4);
    step(1, 3, 0);
    for (int i = 0; i < 60 && m_ph == 3; i++) step(1, 1 + (i % 3), 1);
    wait_phase(0, 5);

    // MISS at rise 6 on the very cycle a tick is due.
    step(1, 1, 0);
    for (int i = 0; i < 60 && !(m_ph == 1 && m_rise == 6 && tick_at(cyc + 1)); i++) step(0, 0, 0);
    step(1, 3, 0);
    wait_phase(0, 60);

    // Hold at the top: auto-miss with the timeout build, indefinite hold without.
    step(1, 1, 7);
    wait_phase(2, 60);
    if (TO_EN) begin
      wait_phase(0, 200);
    end else begin
      repeat (1000 * DIV) step(0, 0, 0);
      o = dut_obs();
      checks++;
      if (o != m_prev || !busy) begin
        errors++;
        $display("FAIL hold_up got %h required %h", o, m_prev);
      end
      step(1, 3, 0);
      wait_phase(0, 60);
    end

    // Asynchronous reset in mid-ascent.
    step(1, 1, 5);
    for (int i = 0; i < 60 && m_rise != 9; i++) step(0, 0, 0);
    cmd_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    o = dut_obs();
    checks++;
    if (o != reset_obs()) begin
      errors++;
      $display("FAIL async_reset got %h required %h", o, reset_obs());
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    step(1, 1, 3);
    wait_phase(2, 60);
    step(1, 2, 0);
    wait_phase(0, 60);

    // Random traffic.
    repeat (800) begin
      if ($urandom_range(0, 2) == 0)
        step(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 11)));
      else
        step(0, 0, 0);
    end
    for (int i = 0; i < 300 && m_ph != 0; i++) step(1, 3, 0);
    repeat (6) step(0, 0, 0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
